air_actuator_ctrl: RTL and testbench
====================================

# air_actuator_ctrl

Downstream consumer of the set-point stage: takes the held set temperature `set_tem`, the measured temperature `tem_reg` and the air-conditioner mode `air_state`, and drives the cooler, heater and fan outputs. The cooler and heater are driven with hysteresis and compressor protection (minimum on time, minimum off time). The fan is driven by a PWM whose duty follows the temperature error. It sits between the set-point/mode logic and the board actuator pins.

## Interface
- `TICK_DIV`, 100_000_000: clk cycles per 1 s tick.
- `HYST`, 2: hysteresis band in °C.
- `MIN_ON`, 30: minimum COOL/HEAT residency, in seconds.
- `MIN_OFF`, 10: LOCKOUT duration, in seconds.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `tem_reg` in 8: measured temperature, unsigned °C.
- `set_tem` in 8: target temperature, unsigned °C.
- `air_state` in 2: encoding is 00 AIR_MANUAL, 01 AIR_AUTO, 10 STOPPED, 11 SET_TEM.
- `manual_cmd` in 2: used only in AIR_MANUAL; 00 off, 01 cool, 10 heat, 11 off.
- `cool_on` out 1: cooler relay.
- `heat_on` out 1: heater relay.
- `fan_pwm` out 1: fan drive.
- `act_state` out 2: current FSM state, for display.

## Operation
- FSM states are IDLE=00, COOL=01, HEAT=10, LOCKOUT=11.
  - `cool_on` = (state==COOL).
  - `heat_on` = (state==HEAT).
  - `act_state` = state.
- `sec_cnt` is an 8-bit counter.
  - Cleared to 0 on every state change.
  - Incremented on each 1 s tick.
  - Saturates at 255.
- Comparisons are done in 9 bits, so `set_tem`+HYST and `tem_reg`+HYST never wrap.
- AIR_AUTO transitions:
  - IDLE→COOL when `tem_reg` ≥ `set_tem`+HYST.
  - IDLE→HEAT when `tem_reg`+HYST ≤ `set_tem`.
  - If neither condition holds, stay in IDLE.
  - COOL→LOCKOUT when `tem_reg` ≤ `set_tem` and `sec_cnt` ≥ MIN_ON.
  - HEAT→LOCKOUT when `tem_reg` ≥ `set_tem` and `sec_cnt` ≥ MIN_ON.
- AIR_MANUAL transitions:
  - IDLE→COOL on `manual_cmd`=01.
  - IDLE→HEAT on `manual_cmd`=10.
  - COOL→LOCKOUT when `manual_cmd`≠01 and `sec_cnt` ≥ MIN_ON.
  - HEAT→LOCKOUT when `manual_cmd`≠10 and `sec_cnt` ≥ MIN_ON.
- STOPPED:
  - COOL/HEAT→LOCKOUT immediately; MIN_ON is overridden for safety.
  - IDLE stays IDLE.
  - LOCKOUT continues counting.
- SET_TEM: the FSM is frozen (no transitions). `sec_cnt` and the prescaler keep running.
- LOCKOUT→IDLE when `sec_cnt` ≥ MIN_OFF, in any mode.
- COOL↔HEAT never happens directly; the path is always through LOCKOUT then IDLE.
- Fan control:
  - `err` = |`tem_reg` − `set_tem`|.
  - Fan level is 0 in IDLE/LOCKOUT. Otherwise level 1 for `err` ≤ 1, level 2 for `err` 2–3, level 3 for `err` ≥ 4.
  - Duty out of 16 is 0 / 4 / 8 / 16 for levels 0 / 1 / 2 / 3.
  - `pwm_cnt` is a 4-bit free-running counter on clk.
  - `fan_pwm` = (`pwm_cnt` < duty); level 3 gives a constant 1 (5-bit compare).

## Timing
- Reset values:
  - State = LOCKOUT, which enforces MIN_OFF after power-up.
  - `sec_cnt`=0, prescaler=0, `pwm_cnt`=0.
  - `cool_on`=0, `heat_on`=0, `fan_pwm`=0, `act_state`=11.
- Reset mid-COOL/HEAT drops the relays asynchronously and re-enters LOCKOUT.
- Inputs are sampled at the clk edge. The state register updates on that edge, and relays follow the state register, so latency is 1 clk from the qualifying input.
- Tick and `sec_cnt`:
  - The tick is a 1-cycle pulse when the prescaler reaches TICK_DIV−1; the prescaler then wraps to 0.
  - The first tick comes TICK_DIV cycles after reset release.
  - The prescaler is not cleared on state change, so the first second in a new state lasts between 1 and TICK_DIV cycles.
  - A tick in the same cycle as a state change is discarded: `sec_cnt` goes to 0.
- Simultaneous events:
  - STOPPED has priority over every other condition.
  - SET_TEM freeze has priority over auto/manual conditions but not over LOCKOUT expiry, so LOCKOUT→IDLE still occurs under SET_TEM.
- Fan: the duty update is registered and follows the state/err of the previous cycle. PWM period is 16 clk.

## Structure
- Shared package `air_pkg` holds:
  - `air_state` encodings (AIR_MANUAL, AIR_AUTO, STOPPED, SET_TEM).
  - `act_state` encodings (IDLE, COOL, HEAT, LOCKOUT).
  - `manual_cmd` encodings.
  - These are also used by the set-point stage and the display.
- One sub-module, `sec_tick_gen` (parameter TICK_DIV; ports clk, reset, tick). It will be reused by the display blink logic.
- FSM, `sec_cnt` and fan PWM stay in the top module.

## Test plan
Bench parameters: TICK_DIV=4, HYST=2, MIN_ON=3, MIN_OFF=2.
- **Reset:** assert reset, release. Outputs 0 and `act_state`=11 immediately; `act_state`=00 after 2 ticks (8 clk + 1).
- **Auto cool cycle:** AUTO, `set_tem`=25, `tem_reg`=27.
  - COOL 1 clk after reaching IDLE.
  - Set `tem_reg`=25 at `sec_cnt`=1: stays COOL until `sec_cnt`=3, then LOCKOUT, then IDLE 2 ticks later.
- **Hysteresis edge:** AUTO, `set_tem`=25.
  - `tem_reg`=26 keeps IDLE indefinitely.
  - `tem_reg`=23 → HEAT.
  - `tem_reg`=24 keeps HEAT.
  - `tem_reg`=25 after MIN_ON → LOCKOUT.
  - `set_tem`=255, `tem_reg`=255: IDLE, no wrap-triggered COOL.
- **STOPPED override:** in HEAT at `sec_cnt`=0, switch to STOPPED. `heat_on`=0 next clk, LOCKOUT; HEAT is not re-entered while STOPPED.
- **SET_TEM freeze and manual path:** COOL in MANUAL, then `air_state`=SET_TEM with `manual_cmd`=00. Stays COOL past MIN_ON. Returning to MANUAL → LOCKOUT next clk.
- **Fan PWM:** COOL with `err`=1, 3, 5. `fan_pwm` high for 4, 8, 16 of every 16 clk. In IDLE, `fan_pwm` is constant 0.

Source files
------------

// File: rtl/air_pkg.sv
// ---------------------------------------------------------------------------
// air_pkg : shared mode / actuator-state / manual-command encodings and fan duty map.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package air_pkg;

   typedef enum logic [1:0] {
      AIR_MANUAL = 2'b00,
      AIR_AUTO   = 2'b01,
      STOPPED    = 2'b10,
      SET_TEM    = 2'b11
   } air_mode_e;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      COOL    = 2'b01,
      HEAT    = 2'b10,
      LOCKOUT = 2'b11
   } act_state_e;

   typedef enum logic [1:0] {
      CMD_OFF     = 2'b00,
      CMD_COOL    = 2'b01,
      CMD_HEAT    = 2'b10,
      CMD_OFF_ALT = 2'b11
   } manual_cmd_e;

   localparam logic [7:0] SEC_MAX  = 8'd255;
   localparam logic [4:0] DUTY_LV1 = 5'd4;
   localparam logic [4:0] DUTY_LV2 = 5'd8;
   localparam logic [4:0] DUTY_LV3 = 5'd16;

   // Duty out of 16; 16 against a 4-bit counter gives a steady high.
   function automatic logic [4:0] fan_duty(input logic active, input logic [7:0] err);
      logic [4:0] duty;
      duty = 5'd0;
      if (active) begin
         if (err <= 8'd1)      duty = DUTY_LV1;
         else if (err <= 8'd3) duty = DUTY_LV2;
         else                  duty = DUTY_LV3;
      end
      return duty;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sec_tick_gen.sv
// ---------------------------------------------------------------------------
// sec_tick_gen : free-running prescaler producing a 1-cycle pulse every TICK_DIV clocks.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sec_tick_gen #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned      CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] presc_q;
   logic [CNT_W-1:0] presc_d;

   assign tick    = (presc_q == LAST);
   assign presc_d = tick ? '0 : presc_q + CNT_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) presc_q <= '0;
      else       presc_q <= presc_d;
   end

endmodule

`default_nettype wire

// File: rtl/air_actuator_ctrl.sv
// ---------------------------------------------------------------------------
// air_actuator_ctrl : cooler/heater FSM with hysteresis, min on/off protection and fan PWM.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module air_actuator_ctrl
   import air_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100_000_000,
   parameter int unsigned HYST     = 2,
   parameter int unsigned MIN_ON   = 30,
   parameter int unsigned MIN_OFF  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tem_reg,
   input  logic [7:0] set_tem,
   input  logic [1:0] air_state,
   input  logic [1:0] manual_cmd,
   output logic       cool_on,
   output logic       heat_on,
   output logic       fan_pwm,
   output logic [1:0] act_state
);

   localparam logic [8:0] HYST_9    = 9'(HYST);
   localparam logic [7:0] MIN_ON_8  = 8'(MIN_ON);
   localparam logic [7:0] MIN_OFF_8 = 8'(MIN_OFF);

   act_state_e state_q, state_d;
   logic [7:0] sec_cnt_q, sec_cnt_d;
   logic [3:0] pwm_cnt_q;
   logic [4:0] duty_q;
   logic       tick;

   logic [8:0] tem_9, set_9;
   logic [7:0] err;
   logic       too_warm, too_cold, min_on_met, min_off_met;

   sec_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_sec_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // 9-bit compare keeps set/tem near 255 from wrapping into a false demand.
   assign tem_9       = {1'b0, tem_reg};
   assign set_9       = {1'b0, set_tem};
   assign too_warm    = (tem_9 >= set_9 + HYST_9);
   assign too_cold    = (tem_9 + HYST_9 <= set_9);
   assign min_on_met  = (sec_cnt_q >= MIN_ON_8);
   assign min_off_met = (sec_cnt_q >= MIN_OFF_8);
   assign err         = (tem_reg >= set_tem) ? (tem_reg - set_tem) : (set_tem - tem_reg);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            case (air_state)
               AIR_AUTO: begin
                  if (too_warm)      state_d = COOL;
                  else if (too_cold) state_d = HEAT;
               end
               AIR_MANUAL: begin
                  if (manual_cmd == CMD_COOL)      state_d = COOL;
                  else if (manual_cmd == CMD_HEAT) state_d = HEAT;
               end
               default: ;
            endcase
         end
         COOL: begin
            case (air_state)
               STOPPED:    state_d = LOCKOUT;
               AIR_AUTO:   if ((tem_reg <= set_tem) && min_on_met) state_d = LOCKOUT;
               AIR_MANUAL: if ((manual_cmd != CMD_COOL) && min_on_met) state_d = LOCKOUT;
               default: ;
            endcase
         end
         HEAT: begin
            case (air_state)
               STOPPED:    state_d = LOCKOUT;
               AIR_AUTO:   if ((tem_reg >= set_tem) && min_on_met) state_d = LOCKOUT;
               AIR_MANUAL: if ((manual_cmd != CMD_HEAT) && min_on_met) state_d = LOCKOUT;
               default: ;
            endcase
         end
         LOCKOUT: if (min_off_met) state_d = IDLE;
         default: state_d = LOCKOUT;
      endcase
   end

   // A tick landing on a state change is dropped so every residency starts at 0.
   always_comb begin
      sec_cnt_d = sec_cnt_q;
      if (state_d != state_q)                      sec_cnt_d = '0;
      else if (tick && (sec_cnt_q != SEC_MAX))     sec_cnt_d = sec_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= LOCKOUT;
         sec_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         sec_cnt_q <= sec_cnt_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_cnt_q <= '0;
         duty_q    <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 4'd1;
         duty_q    <= fan_duty((state_q == COOL) || (state_q == HEAT), err);
      end
   end

   assign fan_pwm   = ({1'b0, pwm_cnt_q} < duty_q);
   assign cool_on   = (state_q == COOL);
   assign heat_on   = (state_q == HEAT);
   assign act_state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_air_actuator_ctrl.sv
// ---------------------------------------------------------------------------
// tb_air_actuator_ctrl : scenario tasks with a queue of expected states / fan duties.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_air_actuator_ctrl;
   import air_pkg::*;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] tem_reg    = 8'd25;
   logic [7:0] set_tem    = 8'd25;
   logic [1:0] air_state  = AIR_AUTO;
   logic [1:0] manual_cmd = CMD_OFF;
   logic       cool_on, heat_on, fan_pwm;
   logic [1:0] act_state;

   typedef struct {
      string      name;
      int         edge_n;
      logic [1:0] st;
   } exp_t;

   exp_t exp_q[$];
   int   fan_q[$];
   int   errors = 0;
   int   checks = 0;

   air_actuator_ctrl #(
      .TICK_DIV (4),
      .HYST     (2),
      .MIN_ON   (3),
      .MIN_OFF  (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tem_reg    (tem_reg),
      .set_tem    (set_tem),
      .air_state  (air_state),
      .manual_cmd (manual_cmd),
      .cool_on    (cool_on),
      .heat_on    (heat_on),
      .fan_pwm    (fan_pwm),
      .act_state  (act_state)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Leaves the bench at the falling edge after rising edge 9 from release, where
   // LOCKOUT has just expired; later ticks are consumed on edges 12, 16, 20, ...
   task automatic reset_to_idle();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (9) @(negedge clk);
   endtask

   task automatic test_reset();
      exp_t e;
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({act_state, cool_on, heat_on, fan_pwm} !== 5'b11_000) begin
         errors++;
         $display("FAIL reset_async: act=%b cool=%b heat=%b fan=%b, expected act=11 and all 0",
                  act_state, cool_on, heat_on, fan_pwm);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         exp_q.push_back('{"reset_lockout", k, (k < 9) ? LOCKOUT : IDLE});
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({act_state, cool_on, heat_on, fan_pwm} !== {e.st, 3'b000}) begin
            errors++;
            $display("FAIL %s edge %0d: act=%b cool=%b heat=%b fan=%b, expected act=%b relays/fan 0",
                     e.name, e.edge_n, act_state, cool_on, heat_on, fan_pwm, e.st);
         end
      end
   endtask

   task automatic test_auto_cool();
      exp_t e;
      air_state = AIR_AUTO; manual_cmd = CMD_OFF; set_tem = 8'd25; tem_reg = 8'd27;
      reset_to_idle();
      for (int k = 10; k <= 30; k++) begin
         if (k == 13) tem_reg = 8'd25;
         exp_q.push_back('{"auto_cool", k, (k <= 20) ? COOL : (k <= 28) ? LOCKOUT : IDLE});
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({act_state, cool_on, heat_on} !== {e.st, e.st == COOL, e.st == HEAT}) begin
            errors++;
            $display("FAIL %s edge %0d: act=%b cool=%b heat=%b, expected act=%b",
                     e.name, e.edge_n, act_state, cool_on, heat_on, e.st);
         end
      end
   endtask

   task automatic test_hysteresis();
      exp_t e;
      air_state = AIR_AUTO; manual_cmd = CMD_OFF; set_tem = 8'd25; tem_reg = 8'd26;
      reset_to_idle();
      for (int k = 10; k <= 70; k++) begin
         case (k)
            30: tem_reg = 8'd23;
            31: tem_reg = 8'd24;
            45: tem_reg = 8'd25;
            54: begin set_tem = 8'd255; tem_reg = 8'd255; end
            64: tem_reg = 8'd254;
            69: begin set_tem = 8'd253; tem_reg = 8'd255; end
            default: ;
         endcase
         exp_q.push_back('{"hysteresis", k, (k < 30) ? IDLE : (k < 45) ? HEAT :
                                            (k < 53) ? LOCKOUT : (k < 69) ? IDLE : COOL});
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({act_state, cool_on, heat_on} !== {e.st, e.st == COOL, e.st == HEAT}) begin
            errors++;
            $display("FAIL %s edge %0d: act=%b cool=%b heat=%b, expected act=%b",
                     e.name, e.edge_n, act_state, cool_on, heat_on, e.st);
         end
      end
   endtask

   task automatic test_stopped();
      exp_t e;
      air_state = AIR_AUTO; manual_cmd = CMD_OFF; set_tem = 8'd25; tem_reg = 8'd23;
      reset_to_idle();
      for (int k = 10; k <= 30; k++) begin
         if (k == 11) air_state = STOPPED;
         exp_q.push_back('{"stopped", k, (k == 10) ? HEAT : (k <= 16) ? LOCKOUT : IDLE});
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({act_state, cool_on, heat_on} !== {e.st, e.st == COOL, e.st == HEAT}) begin
            errors++;
            $display("FAIL %s edge %0d: act=%b cool=%b heat=%b, expected act=%b",
                     e.name, e.edge_n, act_state, cool_on, heat_on, e.st);
         end
      end
   endtask

   task automatic test_set_tem_manual();
      exp_t e;
      air_state = AIR_MANUAL; manual_cmd = CMD_COOL; set_tem = 8'd25; tem_reg = 8'd25;
      reset_to_idle();
      for (int k = 10; k <= 68; k++) begin
         case (k)
            11: begin air_state = SET_TEM; manual_cmd = CMD_OFF; end
            31: air_state = AIR_MANUAL;
            32: air_state = SET_TEM;
            40: manual_cmd = CMD_HEAT;
            45: air_state = AIR_MANUAL;
            46: manual_cmd = CMD_COOL;
            default: ;
         endcase
         exp_q.push_back('{"settem_manual", k, (k <= 30) ? COOL : (k <= 36) ? LOCKOUT :
                                               (k <= 44) ? IDLE : (k <= 56) ? HEAT :
                                               (k <= 64) ? LOCKOUT : (k == 65) ? IDLE : COOL});
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({act_state, cool_on, heat_on} !== {e.st, e.st == COOL, e.st == HEAT}) begin
            errors++;
            $display("FAIL %s edge %0d: act=%b cool=%b heat=%b, expected act=%b",
                     e.name, e.edge_n, act_state, cool_on, heat_on, e.st);
         end
      end
   endtask

   task automatic test_fan();
      int hi;
      int want;
      int waited;
      int offs[4]  = '{1, 3, 5, -5};
      int duty[4]  = '{4, 8, 16, 16};
      air_state = AIR_MANUAL; manual_cmd = CMD_COOL; set_tem = 8'd25; tem_reg = 8'd26;
      reset_to_idle();
      for (int i = 0; i < 4; i++) begin
         tem_reg = 8'(25 + offs[i]);
         fan_q.push_back(duty[i]);
         repeat (3) @(negedge clk);
         hi = 0;
         for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            hi += (fan_pwm === 1'b1) ? 1 : 0;
         end
         want = fan_q.pop_front();
         checks++;
         if (hi != want) begin
            errors++;
            $display("FAIL fan_duty err_offset=%0d: high %0d of 16 clk, expected %0d",
                     offs[i], hi, want);
         end
      end
      manual_cmd = CMD_OFF;
      fan_q.push_back(0);
      waited = 0;
      while ((act_state !== IDLE) && (waited < 40)) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (act_state !== IDLE) begin
         errors++;
         $display("FAIL fan_idle_wait: act=%b after %0d clk, expected 00", act_state, waited);
      end
      repeat (2) @(negedge clk);
      hi = 0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         hi += (fan_pwm !== 1'b0) ? 1 : 0;
      end
      want = fan_q.pop_front();
      checks++;
      if (hi != want) begin
         errors++;
         $display("FAIL fan_idle: high %0d of 32 clk, expected %0d", hi, want);
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      air_state = AIR_AUTO; manual_cmd = CMD_OFF; set_tem = 8'd25; tem_reg = 8'd27;
      reset_to_idle();
      exp_q.push_back('{"async_pre", 10, COOL});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({act_state, cool_on, heat_on} !== {e.st, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL %s edge %0d: act=%b cool=%b heat=%b, expected act=%b",
                  e.name, e.edge_n, act_state, cool_on, heat_on, e.st);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({act_state, cool_on, heat_on, fan_pwm} !== 5'b11_000) begin
         errors++;
         $display("FAIL async_reset_mid_cool: act=%b cool=%b heat=%b fan=%b, expected act=11 and all 0",
                  act_state, cool_on, heat_on, fan_pwm);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_auto_cool();
      test_hysteresis();
      test_stopped();
      test_set_tem_manual();
      test_fan();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
